mem_word_bridge: RTL and testbench
==================================

Name: mem_word_bridge

Overview:
- Parametrised multi-beat bridge between the DATA_W-wide datapath (ALU, RF, ARF) and the MEM_W-wide byte memory.
- Replaces the hand-sequenced low/high byte transfers (byte-select MUX, IR low/high load) with a self-sequencing engine.
- Takes one word request over a valid/ready handshake, issues 1..BEATS consecutive memory beats, and returns an assembled, optionally sign-extended result.
- Sits between the ARF address output / ALU result and the Memory block.

Parameters:
- DATA_W, 16, datapath word width; must equal MEM_W*BEATS.
- MEM_W, 8, memory data width per beat.
- BEATS, 2, DATA_W/MEM_W; power of two, at least 2.
- ADDR_W, 16, memory address width.
- BIG_ENDIAN, 0, beat ordering. 0: lowest address holds bits [MEM_W-1:0]. 1: lowest address holds the most-significant beat.

Ports:
- Clock, input, 1, single clock; everything updates on the rising edge.
- Reset, input, 1, asynchronous, active-low reset.
- req_valid, input, 1, request present.
- req_ready, output, 1, bridge can accept a request.
- req_write, input, 1, 1 = store, 0 = load.
- req_size, input, $clog2(BEATS), number of beats minus 1.
- req_sext, input, 1, sign-extend load results shorter than DATA_W.
- req_addr, input, ADDR_W, byte address of first beat.
- req_wdata, input, DATA_W, store data; right-aligned when fewer than BEATS beats.
- rsp_valid, output, 1, response present.
- rsp_ready, input, 1, consumer accepts the response.
- rsp_rdata, output, DATA_W, assembled load data; 0 for stores.
- rsp_err, output, 1, misaligned request (optional feature only).
- Mem_Address, output, ADDR_W, beat address.
- Mem_Data, output, MEM_W, beat write data.
- Mem_WR, output, 1, 1 = write beat.
- Mem_CS, output, 1, active-low memory select.
- MemOut, input, MEM_W, memory read data; valid combinationally in the same cycle as the address.

Behaviour:
- Reset (async, Reset=0) forces:
  - state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - Mem_CS=1, Mem_WR=0, Mem_Address=0, Mem_Data=0.
  - Beat counter 0.
- Reset mid-transfer aborts immediately; Mem_CS deasserts asynchronously. Beats already written stay written; no response is produced.
- State machine IDLE -> XFER -> RESP -> IDLE.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready at an edge, latch all req_* fields, clear the beat counter and assembly register, and go to XFER.
- XFER, one beat per cycle for N=req_size+1 cycles:
  - Mem_CS=0, Mem_WR=req_write, Mem_Address=req_addr+beat (mod 2^ADDR_W, wraps).
  - Beat i maps to data slice [i*MEM_W +: MEM_W]. With BIG_ENDIAN=1 it maps to slice [(N-1-i)*MEM_W +: MEM_W].
  - Store: Mem_Data = that slice of req_wdata.
  - Load: that slice of the assembly register is captured from MemOut at the edge.
  - After the edge ending beat N-1, go to RESP.
- RESP:
  - rsp_valid=1, and rsp_rdata/rsp_err are held stable until rsp_valid&&rsp_ready.
  - Then go to IDLE; req_ready reasserts the following cycle (no same-cycle re-accept).
- Latency: accept edge, N beat cycles, rsp_valid visible after N edges following accept. Throughput is one request per N+2 cycles.
- Loads shorter than DATA_W:
  - Upper bits are zero-filled.
  - If req_sext=1, upper bits are filled with bit N*MEM_W-1 of the result.
  - req_sext is ignored when N=BEATS and for stores.
- Outside XFER: Mem_CS=1, Mem_WR=0, Mem_Data=0; Mem_Address holds its last value.
- req_* inputs are ignored outside IDLE.

Optional Feature:
- Macro: MEM_WORD_BRIDGE_ALIGN_CHECK_EN.
- Defined:
  - A request whose beats cross a natural BEATS-aligned boundary (req_addr[$clog2(BEATS)-1:0] + N > BEATS) is misaligned.
  - A misaligned request skips XFER entirely (no Mem_CS assertion) and enters RESP with rsp_err=1 and rsp_rdata=0.
- Undefined: rsp_err is tied to 0 and crossing accesses proceed normally, with address wrap.

Decomposition:
- Shared package mem_bridge_pkg holds:
  - the state enum (IDLE/XFER/RESP);
  - the beat-index and lane-select function (endianness-aware slice offset);
  - default width constants.
- One natural sub-module, mem_bridge_lane_assembler: beat-to-slice capture plus zero/sign extension, reusable for the IR load path.

Test Plan (defaults unless stated):
- Reset then idle -> req_ready=1, Mem_CS=1, rsp_valid=0. Assert Reset low mid-XFER -> Mem_CS=1 immediately, no rsp_valid after release.
- Store 16'hA55A at 16'h0010, size=1 -> memory gets [0x10]=5A, [0x11]=A5 on two consecutive cycles with Mem_WR=1. rsp_valid follows with rsp_rdata=0.
- Load, size=0, sext=1, memory [0x20]=8'h9C -> rsp_rdata=16'hFF9C. Same with sext=0 -> 16'h009C.
- BIG_ENDIAN=1, load at 0x30 with [0x30]=12, [0x31]=34 -> 16'h1234. Load at 16'hFFFF -> second beat address 16'h0000.
- Hold rsp_ready=0 for 5 cycles -> rsp_valid/rsp_rdata stable, req_ready=0, a new req_valid is ignored.
- Macro defined, size=1 at 0x0041 -> no Mem_CS=0 cycle, rsp_err=1. Macro undefined -> both beats issued at 0x41 and 0x42, rsp_err=0.

Source files
------------

// File: rtl/mem_bridge_pkg.sv
// -----------------------------------------------------------------------------
// mem_bridge_pkg
// Shared definitions for the multi-beat memory word bridge.
//   - default width constants for the datapath / memory / address
//   - bridge_state_e : IDLE -> XFER -> RESP sequencing states
//   - lane_index()   : which MEM_W-wide slice of the word a beat touches,
//                      taking beat ordering (endianness) into account
//   - lane_offset()  : bit offset of a lane inside the word
// -----------------------------------------------------------------------------
package mem_bridge_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_MEM_W  = 8;
  localparam int DEF_BEATS  = 2;
  localparam int DEF_ADDR_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } bridge_state_e;

  // Beat 'beat' of a transfer whose last beat index is 'last_beat'.
  // Little-endian: beat i -> lane i. Big-endian: the first (lowest-address)
  // beat carries the most-significant lane of the N-beat value.
  function automatic logic [31:0] lane_index(input logic [31:0] beat,
                                             input logic [31:0] last_beat,
                                             input logic        big_endian);
    lane_index = big_endian ? (last_beat - beat) : beat;
  endfunction

  function automatic logic [31:0] lane_offset(input logic [31:0] lane,
                                              input logic [31:0] mem_w);
    lane_offset = lane * mem_w;
  endfunction

endpackage

// File: rtl/mem_bridge_lane_assembler.sv
// -----------------------------------------------------------------------------
// mem_bridge_lane_assembler
// Collects MEM_W-wide beats into a DATA_W-wide word and applies zero/sign
// extension for values shorter than the full word.
//
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_clear        : zero the assembly register (start of a new request)
//   i_capture      : store i_lane_data into lane i_lane at this edge
//   i_lane         : destination lane of the current beat
//   i_size         : beats minus one of the value being assembled
//   i_sext         : fill unused upper lanes with the value's top bit
//   i_lane_data    : beat data from memory
//   o_data         : assembled, extended word
// -----------------------------------------------------------------------------
module mem_bridge_lane_assembler
  import mem_bridge_pkg::*;
#(
  parameter int MEM_W  = DEF_MEM_W,
  parameter int BEATS  = DEF_BEATS,
  parameter int DATA_W = MEM_W * BEATS,
  localparam int SIZE_W = $clog2(BEATS)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clear,
  input  logic              i_capture,
  input  logic [SIZE_W-1:0] i_lane,
  input  logic [SIZE_W-1:0] i_size,
  input  logic              i_sext,
  input  logic [MEM_W-1:0]  i_lane_data,
  output logic [DATA_W-1:0] o_data
);

  logic [DATA_W-1:0] r_asm;
  logic              w_msb;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_asm <= '0;
    end else if (i_clear) begin
      r_asm <= '0;
    end else if (i_capture) begin
      for (int b = 0; b < BEATS; b++) begin
        if (i_lane == SIZE_W'(b)) begin
          r_asm[b*MEM_W +: MEM_W] <= i_lane_data;
        end
      end
    end
  end

  // Only lanes 0..i_size ever receive data, so the lanes above hold zero
  // and only need overriding when sign extension is requested.
  always_comb begin
    w_msb = 1'b0;
    for (int b = 0; b < BEATS; b++) begin
      if (i_size == SIZE_W'(b)) begin
        w_msb = r_asm[b*MEM_W + MEM_W - 1];
      end
    end
    o_data = r_asm;
    for (int b = 0; b < BEATS; b++) begin
      if (SIZE_W'(b) > i_size) begin
        o_data[b*MEM_W +: MEM_W] = {MEM_W{i_sext & w_msb}};
      end
    end
  end

endmodule

// File: rtl/mem_word_bridge.sv
// -----------------------------------------------------------------------------
// mem_word_bridge
// Self-sequencing bridge between a DATA_W datapath and a MEM_W byte memory.
// Accepts one word request, issues req_size+1 consecutive memory beats,
// then presents an assembled (optionally sign-extended) response.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. The producer holds valid and its payload until that edge; the
// bridge never withdraws rsp_valid or changes rsp_rdata/rsp_err before it.
//
// Ports:
//   Clock, Reset             : clock, asynchronous active-low reset
//   req_valid/req_ready      : request handshake
//   req_write, req_size,
//   req_sext, req_addr,
//   req_wdata                : request payload (size = beats minus one)
//   rsp_valid/rsp_ready      : response handshake
//   rsp_rdata, rsp_err       : response payload
//   Mem_Address, Mem_Data,
//   Mem_WR, Mem_CS           : memory beat interface (Mem_CS active low)
//   MemOut                   : combinational memory read data
//   o_dbg_state              : current sequencing state
//
// Build option: MEM_WORD_BRIDGE_ALIGN_CHECK_EN rejects requests that cross a
// BEATS-aligned boundary (rsp_err=1, no memory access). Without it, rsp_err
// is 0 and crossing requests simply run on with address wrap.
// -----------------------------------------------------------------------------
module mem_word_bridge
  import mem_bridge_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int MEM_W      = DEF_MEM_W,
  parameter int BEATS      = DEF_BEATS,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int BIG_ENDIAN = 0,
  localparam int SIZE_W    = $clog2(BEATS)
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [SIZE_W-1:0] req_size,
  input  logic              req_sext,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] Mem_Address,
  output logic [MEM_W-1:0]  Mem_Data,
  output logic              Mem_WR,
  output logic              Mem_CS,
  input  logic [MEM_W-1:0]  MemOut,
  output logic [1:0]        o_dbg_state
);

  if (DATA_W != MEM_W * BEATS) begin : g_bad_width
    $error("mem_word_bridge: DATA_W must equal MEM_W*BEATS");
  end
  if (BEATS < 2 || (BEATS & (BEATS - 1)) != 0) begin : g_bad_beats
    $error("mem_word_bridge: BEATS must be a power of two, at least 2");
  end

  bridge_state_e     r_state;
  bridge_state_e     w_state_nxt;

  logic              r_write;
  logic [SIZE_W-1:0] r_size;
  logic              r_sext;
  logic [DATA_W-1:0] r_wdata;
  logic [SIZE_W-1:0] r_beat;
  logic [ADDR_W-1:0] r_mem_addr;

  logic              w_accept;
  logic              w_capture;
  logic              w_last;
  logic              w_misalign;
  logic [SIZE_W-1:0] w_lane;
  logic [DATA_W-1:0] w_asm_data;

`ifdef MEM_WORD_BRIDGE_ALIGN_CHECK_EN
  logic              r_err;

  // lo + N > BEATS  <=>  lo + (N-1) >= BEATS; one extra bit avoids overflow.
  assign w_misalign = ({1'b0, req_addr[SIZE_W-1:0]} + {1'b0, req_size})
                      >= (SIZE_W+1)'(BEATS);
  assign rsp_err    = (r_state == RESP) & r_err;
`else
  assign w_misalign = 1'b0;
  assign rsp_err    = 1'b0;
`endif

  assign w_last      = (r_beat == r_size);
  assign w_lane      = SIZE_W'(lane_index(32'(r_beat), 32'(r_size),
                                          BIG_ENDIAN != 0));
  assign Mem_Address = r_mem_addr;
  assign rsp_rdata   = (r_state == RESP) ? w_asm_data : '0;
  assign o_dbg_state = r_state;

  // State register
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and memory/handshake outputs
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    Mem_CS      = 1'b1;
    Mem_WR      = 1'b0;
    Mem_Data    = '0;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = w_misalign ? RESP : XFER;
        end
      end
      XFER: begin
        Mem_CS    = 1'b0;
        Mem_WR    = r_write;
        w_capture = ~r_write;
        if (r_write) begin
          Mem_Data = r_wdata[lane_offset(32'(w_lane), 32'(MEM_W)) +: MEM_W];
        end
        if (w_last) begin
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Request latch, beat counter and beat address
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_write    <= 1'b0;
      r_size     <= '0;
      r_sext     <= 1'b0;
      r_wdata    <= '0;
      r_beat     <= '0;
      r_mem_addr <= '0;
    end else if (w_accept) begin
      r_write <= req_write;
      r_size  <= req_size;
      // Extension only applies to loads.
      r_sext  <= req_sext & ~req_write;
      r_wdata <= req_wdata;
      r_beat  <= '0;
      // A rejected request never drives the bus, so the address keeps
      // showing the last beat actually issued.
      if (!w_misalign) begin
        r_mem_addr <= req_addr;
      end
    end else if (r_state == XFER && !w_last) begin
      r_beat     <= r_beat + SIZE_W'(1);
      r_mem_addr <= r_mem_addr + ADDR_W'(1);
    end
  end

`ifdef MEM_WORD_BRIDGE_ALIGN_CHECK_EN
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_err <= w_misalign;
    end
  end
`endif

  mem_bridge_lane_assembler #(
    .MEM_W (MEM_W),
    .BEATS (BEATS),
    .DATA_W(DATA_W)
  ) u_assembler (
    .i_clk      (Clock),
    .i_rst_n    (Reset),
    .i_clear    (w_accept),
    .i_capture  (w_capture),
    .i_lane     (w_lane),
    .i_size     (r_size),
    .i_sext     (r_sext),
    .i_lane_data(MemOut),
    .o_data     (w_asm_data)
  );

endmodule

// File: tb/tb_mem_word_bridge.sv
module tb_mem_word_bridge;

  // ---------------- clock / reset ----------------
  logic Clock = 1'b0;
  logic Reset = 1'b0;
  always #5 Clock = ~Clock;

  // ---------------- little-endian DUT ----------------
  logic        req_valid = 0, req_ready, req_write = 0, req_sext = 0;
  logic [0:0]  req_size = 0;
  logic [15:0] req_addr = 0, req_wdata = 0;
  logic        rsp_valid, rsp_ready = 0, rsp_err;
  logic [15:0] rsp_rdata, Mem_Address;
  logic [7:0]  Mem_Data, MemOut;
  logic        Mem_WR, Mem_CS;
  logic [1:0]  dbg_state;

  // ---------------- big-endian DUT ----------------
  logic        be_req_valid = 0, be_req_ready, be_req_write = 0, be_req_sext = 0;
  logic [0:0]  be_req_size = 0;
  logic [15:0] be_req_addr = 0, be_req_wdata = 0;
  logic        be_rsp_valid, be_rsp_ready = 0, be_rsp_err;
  logic [15:0] be_rsp_rdata, be_Mem_Address;
  logic [7:0]  be_Mem_Data, be_MemOut;
  logic        be_Mem_WR, be_Mem_CS;
  logic [1:0]  be_dbg_state;

  mem_word_bridge u_dut (
    .Clock(Clock), .Reset(Reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_sext(req_sext), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .Mem_Address(Mem_Address),
    .Mem_Data(Mem_Data), .Mem_WR(Mem_WR), .Mem_CS(Mem_CS), .MemOut(MemOut),
    .o_dbg_state(dbg_state)
  );

  mem_word_bridge #(.BIG_ENDIAN(1)) u_dut_be (
    .Clock(Clock), .Reset(Reset),
    .req_valid(be_req_valid), .req_ready(be_req_ready), .req_write(be_req_write),
    .req_size(be_req_size), .req_sext(be_req_sext), .req_addr(be_req_addr),
    .req_wdata(be_req_wdata), .rsp_valid(be_rsp_valid), .rsp_ready(be_rsp_ready),
    .rsp_rdata(be_rsp_rdata), .rsp_err(be_rsp_err), .Mem_Address(be_Mem_Address),
    .Mem_Data(be_Mem_Data), .Mem_WR(be_Mem_WR), .Mem_CS(be_Mem_CS), .MemOut(be_MemOut),
    .o_dbg_state(be_dbg_state)
  );

  // ---------------- memory (written only by the LE DUT) ----------------
  logic [7:0] mem     [0:65535];
  logic [7:0] ref_mem [0:65535];
  assign MemOut    = mem[Mem_Address];
  assign be_MemOut = mem[be_Mem_Address];
  always @(posedge Clock) if (!Mem_CS && Mem_WR) mem[Mem_Address] <= Mem_Data;

  // ---------------- scoreboard ----------------
  int n_vec  = 0;
  int n_fail = 0;
  logic [24:0] exp_beat_q[$];   // {wr, addr, data}
  logic [16:0] exp_rsp_q[$];    // {err, rdata}
  logic [24:0] be_trace[$];     // {wr, addr, data} seen on the BE bus

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_byte(input logic [15:0] a, input logic [7:0] d);
    mem[a] = d;
    ref_mem[a] = d;
  endtask

  // Behavioural model: what a request must do, from the bridge rules.
  task automatic model_req(input logic w, input logic [0:0] sz, input logic sx,
                           input logic [15:0] a, input logic [15:0] wd, output int lat);
    int n;
    bit mis;
    logic [31:0] val;
    logic [15:0] ba;
    logic [7:0]  bt;
    n   = int'(sz) + 1;
    mis = 0;
    val = 0;
`ifdef MEM_WORD_BRIDGE_ALIGN_CHECK_EN
    mis = (int'(a[0]) + n) > 2;
`endif
    if (mis) begin
      exp_rsp_q.push_back({1'b1, 16'h0000});
      lat = 0;
    end else begin
      for (int i = 0; i < n; i++) begin
        ba = a + 16'(i);
        if (w) begin
          bt = wd[8*i +: 8];
          exp_beat_q.push_back({1'b1, ba, bt});
          ref_mem[ba] = bt;
        end else begin
          exp_beat_q.push_back({1'b0, ba, 8'h00});
          val = val | (32'(ref_mem[ba]) << (8*i));
        end
      end
      if (!w && n < 2 && sx && val[8*n-1]) val = val | ~((32'd1 << (8*n)) - 1);
      exp_rsp_q.push_back({1'b0, w ? 16'h0000 : val[15:0]});
      lat = n;
    end
  endtask

  // Compare process: every cycle out of reset, bus and response vs model.
  always @(negedge Clock) begin
    if (Reset) begin
      if (!Mem_CS) begin
        if (exp_beat_q.size() == 0) begin
          chk("unexpected_beat", {7'd0, Mem_WR, Mem_Address, Mem_Data}, 32'h0);
        end else begin
          logic [24:0] b;
          b = exp_beat_q.pop_front();
          if (b[24]) chk("beat_store", {7'd0, Mem_WR, Mem_Address, Mem_Data}, {7'd0, b});
          else       chk("beat_load", {15'd0, Mem_WR, Mem_Address}, {15'd0, b[24:8]});
        end
      end else begin
        chk("idle_bus", {23'd0, Mem_WR, Mem_Data}, 32'h0);
      end
      if (rsp_valid) begin
        if (exp_rsp_q.size() == 0) begin
          chk("unexpected_rsp", {15'd0, rsp_err, rsp_rdata}, 32'h0);
        end else begin
          chk("rsp", {15'd0, rsp_err, rsp_rdata}, {15'd0, exp_rsp_q[0]});
          if (rsp_ready) void'(exp_rsp_q.pop_front());
        end
      end
    end
  end

  always @(negedge Clock)
    if (Reset && !be_Mem_CS) be_trace.push_back({be_Mem_WR, be_Mem_Address, be_Mem_Data});

  // ---------------- driver tasks (start/end at posedge+1) ----------------
  task automatic send(input logic w, input logic [0:0] sz, input logic sx,
                      input logic [15:0] a, input logic [15:0] wd, input int hold,
                      output logic [15:0] rd, output logic er);
    int lat, cnt;
    logic [15:0] first_rd;
    model_req(w, sz, sx, a, wd, lat);
    req_write = w; req_size = sz; req_sext = sx; req_addr = a; req_wdata = wd;
    req_valid = 1;
    cnt = 0;
    while (!req_ready && cnt < 20) begin @(posedge Clock); #1; cnt++; end
    chk("req_ready_wait", {31'd0, req_ready}, 32'd1);
    @(posedge Clock); #1;
    req_valid = 0;
    cnt = 0;
    while (!rsp_valid && cnt < 20) begin @(posedge Clock); #1; cnt++; end
    chk("latency", cnt, lat);
    first_rd = rsp_rdata;
    for (int h = 0; h < hold; h++) begin
      chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
      chk("hold_rdata", {16'd0, rsp_rdata}, {16'd0, first_rd});
      // Stray request while busy: must be ignored.
      req_valid = 1; req_write = 1; req_size = 1; req_addr = 16'h0099; req_wdata = 16'hDEAD;
      @(posedge Clock); #1;
    end
    req_valid = 0;
    rsp_ready = 1;
    rd = rsp_rdata;
    er = rsp_err;
    @(posedge Clock); #1;
    rsp_ready = 0;
    chk("after_rsp", {30'd0, req_ready, rsp_valid}, 32'd2);
  endtask

  task automatic be_send(input logic w, input logic [0:0] sz, input logic sx,
                         input logic [15:0] a, input logic [15:0] wd,
                         output logic [15:0] rd, output logic er);
    int cnt;
    be_trace.delete();
    be_req_write = w; be_req_size = sz; be_req_sext = sx; be_req_addr = a; be_req_wdata = wd;
    be_req_valid = 1;
    @(posedge Clock); #1;
    be_req_valid = 0;
    cnt = 0;
    while (!be_rsp_valid && cnt < 20) begin @(posedge Clock); #1; cnt++; end
    chk("be_rsp_wait", {31'd0, be_rsp_valid}, 32'd1);
    be_rsp_ready = 1;
    rd = be_rsp_rdata;
    er = be_rsp_err;
    @(posedge Clock); #1;
    be_rsp_ready = 0;
  endtask

  // ---------------- stimulus ----------------
  logic [15:0] rd;
  logic        er;
  bit          align_en;

  initial begin
    align_en = 0;
`ifdef MEM_WORD_BRIDGE_ALIGN_CHECK_EN
    align_en = 1;
`endif
    for (int i = 0; i < 65536; i++) set_byte(16'(i), 8'(i) ^ 8'h5A);
    set_byte(16'h0020, 8'h9C);
    set_byte(16'h0030, 8'h12);
    set_byte(16'h0031, 8'h34);
    set_byte(16'h0041, 8'h77);
    set_byte(16'h0042, 8'h88);
    set_byte(16'hFFFF, 8'hAB);
    set_byte(16'h0000, 8'hCD);

    // Reset values
    #2;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_mem_cs", {31'd0, Mem_CS}, 32'd1);
    chk("rst_rsp", {14'd0, rsp_valid, rsp_err, rsp_rdata}, 32'd0);
    chk("rst_bus", {7'd0, Mem_WR, Mem_Address, Mem_Data}, 32'd0);
    repeat (2) @(posedge Clock);
    @(negedge Clock); #1;
    Reset = 1;
    @(posedge Clock); #1;
    chk("idle_req_ready", {30'd0, req_ready, Mem_CS}, 32'd3);

    // LE store / loads
    send(1, 1, 0, 16'h0010, 16'hA55A, 0, rd, er);
    chk("st_rdata", {15'd0, er, rd}, 32'h0);
    chk("st_mem10", {24'd0, mem[16'h0010]}, 32'h5A);
    chk("st_mem11", {24'd0, mem[16'h0011]}, 32'hA5);
    send(0, 0, 1, 16'h0020, 16'h0, 0, rd, er);
    chk("ld8_sext", {16'd0, rd}, 32'hFF9C);
    send(0, 0, 0, 16'h0020, 16'h0, 0, rd, er);
    chk("ld8_zext", {16'd0, rd}, 32'h009C);
    send(0, 1, 1, 16'h0010, 16'h0, 0, rd, er);
    chk("ld16_sext_ignored", {16'd0, rd}, 32'hA55A);
    send(1, 0, 1, 16'h0060, 16'h12F0, 0, rd, er);
    chk("st8_rdata", {16'd0, rd}, 32'h0);
    send(0, 0, 1, 16'h0060, 16'h0, 0, rd, er);
    chk("st8_readback", {16'd0, rd}, 32'hFFF0);
    chk("st8_upper_untouched", {24'd0, mem[16'h0061]}, {24'd0, 8'h61 ^ 8'h5A});
    send(0, 1, 0, 16'h0030, 16'h0, 5, rd, er);
    chk("ld16_hold", {16'd0, rd}, 32'h3412);
    chk("stray_ignored", {24'd0, mem[16'h0099]}, {24'd0, 8'h99 ^ 8'h5A});
    send(0, 1, 0, 16'h0041, 16'h0, 0, rd, er);
    chk("ld_cross", {15'd0, er, rd}, align_en ? 32'h10000 : 32'h8877);
    send(0, 1, 0, 16'hFFFF, 16'h0, 0, rd, er);
    chk("ld_wrap", {15'd0, er, rd}, align_en ? 32'h10000 : 32'hCDAB);
    send(0, 1, 1, 16'h0042, 16'h0, 0, rd, er);
    chk("ld16_aligned", {15'd0, er, rd}, {15'd0, 1'b0, ref_mem[16'h0043], 8'h88});

    // BE instance
    be_send(0, 1, 0, 16'h0030, 16'h0, rd, er);
    chk("be_ld16", {15'd0, er, rd}, 32'h1234);
    chk("be_ld16_beats", be_trace.size(), 2);
    if (be_trace.size() == 2) chk("be_ld16_addr", {be_trace[0][23:8], be_trace[1][23:8]}, 32'h00300031);
    be_send(0, 1, 0, 16'hFFFF, 16'h0, rd, er);
    chk("be_wrap", {15'd0, er, rd}, align_en ? 32'h10000 : 32'hABCD);
    chk("be_wrap_beats", be_trace.size(), align_en ? 0 : 2);
    if (be_trace.size() == 2) chk("be_wrap_addr", {be_trace[0][23:8], be_trace[1][23:8]}, 32'hFFFF0000);
    be_send(0, 0, 1, 16'h0020, 16'h0, rd, er);
    chk("be_ld8_sext", {16'd0, rd}, 32'hFF9C);
    be_send(1, 1, 0, 16'h0070, 16'hA55A, rd, er);
    chk("be_st_rdata", {16'd0, rd}, 32'h0);
    chk("be_st_beats", be_trace.size(), 2);
    if (be_trace.size() == 2) chk("be_st_data", {7'd0, be_trace[0]}, {7'd0, 1'b1, 16'h0070, 8'hA5});
    if (be_trace.size() == 2) chk("be_st_data1", {7'd0, be_trace[1]}, {7'd0, 1'b1, 16'h0071, 8'h5A});

    // Reset in the middle of a transfer
    exp_beat_q.push_back({1'b0, 16'h0050, 8'h00});
    req_write = 0; req_size = 1; req_sext = 0; req_addr = 16'h0050; req_valid = 1;
    @(posedge Clock); #1;
    req_valid = 0;
    chk("mid_xfer_cs", {31'd0, Mem_CS}, 32'd0);
    @(negedge Clock); #2;
    Reset = 0;
    #1;
    chk("abort_cs", {31'd0, Mem_CS}, 32'd1);
    chk("abort_state", {29'd0, req_ready, rsp_valid, Mem_WR}, 32'd4);
    chk("abort_addr", {16'd0, Mem_Address}, 32'd0);
    exp_beat_q.delete();
    exp_rsp_q.delete();
    @(negedge Clock); #1;
    Reset = 1;
    repeat (6) begin
      @(posedge Clock); #1;
      chk("no_rsp_after_abort", {31'd0, rsp_valid}, 32'd0);
    end
    send(0, 0, 0, 16'h0020, 16'h0, 0, rd, er);
    chk("post_abort_ld", {16'd0, rd}, 32'h009C);

    repeat (3) @(posedge Clock);
    chk("beat_q_drained", exp_beat_q.size(), 0);
    chk("rsp_q_drained", exp_rsp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
